// File: rtl/pn_arbiter.sv
// pn_arbiter: round-robin owner of one shared Polish Notation core.
// Grants one requester at a time, forwards its token burst to the core
// through one register stage, tags core results with the owner ID and
// closes each transaction with a res_done pulse carrying count and error.
module pn_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned MAX_TOK = 12,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic [2*N-1:0]         req_mode,
   input  logic [N-1:0]           req_operator,
   input  logic [3*N-1:0]         req_in,
   input  logic [N-1:0]           req_in_valid,
   output logic [N-1:0]           grant,
   output logic [1:0]             core_mode,
   output logic                   core_operator,
   output logic [2:0]             core_in,
   output logic                   core_in_valid,
   input  logic                   core_out_valid,
   input  logic signed [31:0]     core_out,
   output logic                   res_valid,
   output logic signed [31:0]     res_data,
   output logic [ID_W-1:0]        res_id,
   output logic                   res_done,
   output logic                   res_err,
   output logic [2:0]             res_cnt
);

   localparam int unsigned TOK_W = $clog2(MAX_TOK + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

   state_t            state;
   logic [ID_W-1:0]   last;
   logic [ID_W-1:0]   owner;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   cand;
   logic              found;
   logic [N-1:0]      pick_hot;
   logic [TOK_W-1:0]  tok_cnt;
   logic [WD_W-1:0]   wd;
   logic [2:0]        res_count;
   logic              err;
   logic [1:0]        sel_mode;
   logic              sel_op;
   logic [2:0]        sel_in;
   logic              sel_valid;
   logic              wd_expired;

   // Round-robin search: first requesting channel after the previous owner
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      cand     = '0;
      pick_hot = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = ID_W'((32'(last) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         pick_hot[i] = (pick == ID_W'(i));
      end
   end

   // Token-side mux selecting the current owner's channel
   always_comb begin
      sel_mode  = '0;
      sel_op    = 1'b0;
      sel_in    = '0;
      sel_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (owner == ID_W'(i)) begin
            sel_mode  = req_mode[2*i +: 2];
            sel_op    = req_operator[i];
            sel_in    = req_in[3*i +: 3];
            sel_valid = req_in_valid[i];
         end
      end
   end

   assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

   // Transaction FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         last          <= ID_W'(N - 1);
         owner         <= '0;
         grant         <= '0;
         core_mode     <= '0;
         core_operator <= 1'b0;
         core_in       <= '0;
         core_in_valid <= 1'b0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_id        <= '0;
         res_done      <= 1'b0;
         res_err       <= 1'b0;
         res_cnt       <= '0;
         tok_cnt       <= '0;
         wd            <= '0;
         res_count     <= '0;
         err           <= 1'b0;
      end else begin
         res_valid     <= 1'b0;
         res_done      <= 1'b0;
         core_in_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant <= pick_hot;
                  owner <= pick;
                  wd    <= '0;
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               core_mode     <= sel_mode;
               core_operator <= sel_op;
               core_in       <= sel_in;
               wd            <= wd + WD_W'(1);
               if (sel_valid) begin
                  if (tok_cnt == TOK_W'(MAX_TOK)) begin
                     err <= 1'b1;
                  end else begin
                     tok_cnt       <= tok_cnt + TOK_W'(1);
                     core_in_valid <= 1'b1;
                  end
               end else if (tok_cnt != '0) begin
                  grant <= '0;
                  wd    <= '0;
                  state <= S_WAIT;
               end else if (wd_expired) begin
                  grant    <= '0;
                  res_done <= 1'b1;
                  res_id   <= owner;
                  res_cnt  <= res_count;
                  res_err  <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_WAIT: begin
               wd <= wd + WD_W'(1);
               if (core_out_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= core_out;
                  res_id    <= owner;
                  if (res_count != 3'd4) res_count <= res_count + 3'd1;
               end else if (res_count != '0 || wd_expired) begin
                  res_done <= 1'b1;
                  res_id   <= owner;
                  res_cnt  <= res_count;
                  res_err  <= err | (res_count == '0);
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               last      <= owner;
               tok_cnt   <= '0;
               wd        <= '0;
               res_count <= '0;
               err       <= 1'b0;
               res_cnt   <= '0;
               res_err   <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pn_arbiter.sv
// Directed testbench for pn_arbiter; the bench plays the role of the PN core.
module tb_pn_arbiter;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [3:0]         req = '0;
   logic [7:0]         req_mode = '0;
   logic [3:0]         req_operator = '0;
   logic [11:0]        req_in = '0;
   logic [3:0]         req_in_valid = '0;
   logic [3:0]         grant;
   logic [1:0]         core_mode;
   logic               core_operator;
   logic [2:0]         core_in;
   logic               core_in_valid;
   logic               core_out_valid = 1'b0;
   logic signed [31:0] core_out = '0;
   logic               res_valid;
   logic signed [31:0] res_data;
   logic [1:0]         res_id;
   logic               res_done;
   logic               res_err;
   logic [2:0]         res_cnt;

   int checks = 0;
   int passes = 0;
   logic seen;

   pn_arbiter #(.N(4), .ID_W(2), .MAX_TOK(12), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .req(req), .req_mode(req_mode),
      .req_operator(req_operator), .req_in(req_in), .req_in_valid(req_in_valid),
      .grant(grant), .core_mode(core_mode), .core_operator(core_operator),
      .core_in(core_in), .core_in_valid(core_in_valid),
      .core_out_valid(core_out_valid), .core_out(core_out),
      .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
      .res_done(res_done), .res_err(res_err), .res_cnt(res_cnt)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_tok(input int ch, input logic op, input logic [2:0] val, input logic exp_v);
      req_operator      = '0;
      req_operator[ch]  = op;
      req_in[3*ch +: 3] = val;
      req_in_valid      = '0;
      req_in_valid[ch]  = 1'b1;
      tick;
      chk("core_in_valid", 32'(core_in_valid), 32'(exp_v));
      if (exp_v) begin
         chk("core_in", 32'(core_in), 32'(val));
         chk("core_operator", 32'(core_operator), 32'(op));
      end
   endtask

   // One-token, one-result transaction on channel ch, starting from IDLE
   task automatic txn1(input int ch, input logic [31:0] result);
      logic [3:0] eg;
      eg = '0;
      eg[ch] = 1'b1;
      tick;
      chk("txn_grant", 32'(grant), 32'(eg));
      req_mode[2*ch +: 2] = 2'd3;
      drive_tok(ch, 1'b0, 3'd5, 1'b1);
      req_in_valid = '0;
      tick;
      chk("txn_grant_off", 32'(grant), 32'd0);
      core_out_valid = 1'b1;
      core_out = result;
      tick;
      chk("txn_res_valid", 32'(res_valid), 32'd1);
      chk("txn_res_data", res_data, result);
      chk("txn_res_id", 32'(res_id), 32'(ch));
      core_out_valid = 1'b0;
      tick;
      chk("txn_done", 32'(res_done), 32'd1);
      chk("txn_done_id", 32'(res_id), 32'(ch));
      chk("txn_cnt", 32'(res_cnt), 32'd1);
      chk("txn_err", 32'(res_err), 32'd0);
      tick;
      chk("txn_done_off", 32'(res_done), 32'd0);
      chk("txn_gap_grant", 32'(grant), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) tick;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_core_in_valid", 32'(core_in_valid), 32'd0);
      chk("rst_core_mode", 32'(core_mode), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_done", 32'(res_done), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      rst = 1'b0;
      tick;

      // Single requester ch1, mode 3, tokens 3,4,op0; core noise in IDLE/SEND dropped
      req = 4'b0010;
      core_out_valid = 1'b1;
      core_out = 32'd99;
      tick;
      chk("t1_grant", 32'(grant), 32'h2);
      chk("t1_idle_discard", 32'(res_valid), 32'd0);
      req = '0;
      req_mode[3:2] = 2'd3;
      drive_tok(1, 1'b0, 3'd3, 1'b1);
      chk("t1_core_mode", 32'(core_mode), 32'd3);
      drive_tok(1, 1'b0, 3'd4, 1'b1);
      drive_tok(1, 1'b1, 3'd0, 1'b1);
      chk("t1_send_discard", 32'(res_valid), 32'd0);
      core_out_valid = 1'b0;
      req_in_valid = '0;
      tick;
      chk("t1_grant_off", 32'(grant), 32'd0);
      chk("t1_civ_off", 32'(core_in_valid), 32'd0);
      core_out_valid = 1'b1;
      core_out = 32'sd7;
      tick;
      chk("t1_res_valid", 32'(res_valid), 32'd1);
      chk("t1_res_data", res_data, 32'd7);
      chk("t1_res_id", 32'(res_id), 32'd1);
      chk("t1_no_done_yet", 32'(res_done), 32'd0);
      core_out_valid = 1'b0;
      tick;
      chk("t1_done", 32'(res_done), 32'd1);
      chk("t1_cnt", 32'(res_cnt), 32'd1);
      chk("t1_err", 32'(res_err), 32'd0);
      chk("t1_done_id", 32'(res_id), 32'd1);
      tick;
      chk("t1_done_off", 32'(res_done), 32'd0);

      // Mode 0 burst on ch0: 6 tokens, two results; ch3 strobe ignored
      req = 4'b0001;
      tick;
      chk("t2_grant", 32'(grant), 32'h1);
      req = '0;
      req_mode[1:0] = 2'd0;
      drive_tok(0, 1'b1, 3'd2, 1'b1);
      drive_tok(0, 1'b0, 3'd2, 1'b1);
      drive_tok(0, 1'b0, 3'd3, 1'b1);
      drive_tok(0, 1'b1, 3'd0, 1'b1);
      drive_tok(0, 1'b0, 3'd1, 1'b1);
      drive_tok(0, 1'b0, 3'd1, 1'b1);
      req_in_valid = 4'b1000;
      tick;
      chk("t2_grant_off", 32'(grant), 32'd0);
      chk("t2_foreign_valid", 32'(core_in_valid), 32'd0);
      req_in_valid = '0;
      core_out_valid = 1'b1;
      core_out = 32'sd6;
      tick;
      chk("t2_res0", res_data, 32'd6);
      chk("t2_res0_id", 32'(res_id), 32'd0);
      core_out = 32'sd2;
      tick;
      chk("t2_res1", res_data, 32'd2);
      chk("t2_res1_valid", 32'(res_valid), 32'd1);
      core_out_valid = 1'b0;
      tick;
      chk("t2_done", 32'(res_done), 32'd1);
      chk("t2_cnt", 32'(res_cnt), 32'd2);
      chk("t2_err", 32'(res_err), 32'd0);
      tick;

      // Fairness from a fresh reset, all requests held high
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req = 4'b1111;
      txn1(0, 32'hFFFF_FFFB);
      txn1(1, 32'd11);
      txn1(2, 32'd22);
      txn1(3, 32'd33);
      txn1(0, 32'h8000_0000);
      req = 4'b0100;

      // SEND timeout on ch2: no tokens ever
      tick;
      chk("t4_grant", 32'(grant), 32'h4);
      req = '0;
      seen = 1'b0;
      repeat (63) begin
         tick;
         seen = seen | core_in_valid | res_done;
      end
      chk("t4_quiet_before_timeout", 32'(seen), 32'd0);
      tick;
      chk("t4_done", 32'(res_done), 32'd1);
      chk("t4_err", 32'(res_err), 32'd1);
      chk("t4_cnt", 32'(res_cnt), 32'd0);
      chk("t4_id", 32'(res_id), 32'd2);
      tick;
      chk("t4_done_off", 32'(res_done), 32'd0);

      // Overflow on ch3: 14 tokens, only 12 forwarded
      req = 4'b1000;
      tick;
      chk("t5_grant", 32'(grant), 32'h8);
      req = '0;
      for (int i = 0; i < 14; i++) drive_tok(3, 1'b0, 3'(i % 8), i < 12);
      req_in_valid = '0;
      tick;
      chk("t5_grant_off", 32'(grant), 32'd0);
      core_out_valid = 1'b1;
      core_out = 32'sd123;
      tick;
      chk("t5_res", res_data, 32'd123);
      core_out_valid = 1'b0;
      tick;
      chk("t5_done", 32'(res_done), 32'd1);
      chk("t5_err", 32'(res_err), 32'd1);
      chk("t5_cnt", 32'(res_cnt), 32'd1);
      chk("t5_id", 32'(res_id), 32'd3);
      tick;

      // Reset while waiting for a result
      req = 4'b0001;
      tick;
      chk("t6_grant", 32'(grant), 32'h1);
      req = '0;
      drive_tok(0, 1'b0, 3'd1, 1'b1);
      req_in_valid = '0;
      repeat (2) tick;
      rst = 1'b1;
      core_out_valid = 1'b1;
      core_out = 32'sd9;
      tick;
      chk("t6_grant", 32'(grant), 32'd0);
      chk("t6_civ", 32'(core_in_valid), 32'd0);
      chk("t6_res_valid", 32'(res_valid), 32'd0);
      chk("t6_res_done", 32'(res_done), 32'd0);
      chk("t6_res_data", res_data, 32'd0);
      chk("t6_res_id", 32'(res_id), 32'd0);
      rst = 1'b0;
      core_out_valid = 1'b0;
      tick;
      chk("t6_no_done", 32'(res_done), 32'd0);
      chk("t6_no_valid", 32'(res_valid), 32'd0);
      req = 4'b1111;
      txn1(0, 32'd9);
      req = '0;
      tick;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
